// File: rtl/lbr_drain_if.sv
// Bundled LBR read port and record stream between the drain reader (master)
// and the LBR unit / downstream sink (slave).
interface lbr_drain_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDRESS_BITS = 12,
    parameter int INDEX_BITS   = 3
);
    logic [1:0]              lbr_req;
    logic [DATA_WIDTH-1:0]   lbr_addr;
    logic [DATA_WIDTH-1:0]   lbr_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDRESS_BITS-1:0] out_from;
    logic [ADDRESS_BITS-1:0] out_to;
    logic [INDEX_BITS-1:0]   out_index;

    modport master (
        output lbr_req,
        output lbr_addr,
        input  lbr_data,
        output out_valid,
        input  out_ready,
        output out_from,
        output out_to,
        output out_index
    );

    modport slave (
        input  lbr_req,
        input  lbr_addr,
        output lbr_data,
        input  out_valid,
        output out_ready,
        input  out_from,
        input  out_to,
        input  out_index
    );
endinterface

// File: rtl/lbr_drain_reader.sv
// Walks every LBR entry, pairs source/target PCs and streams them as records.
// Define LBR_CLEAR_ON_DRAIN_EN to issue a one-cycle LBR clear before done.
module lbr_drain_reader #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDRESS_BITS = 12,
    parameter int LBR_DEPTH    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    lbr_drain_if.master bus,
    output logic        busy,
    output logic        done
);
    localparam int INDEX_BITS = $clog2(LBR_DEPTH);
    localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(LBR_DEPTH - 1);

    localparam logic [1:0] REQ_NONE  = 2'b00;
    localparam logic [1:0] REQ_READ  = 2'b10;
    localparam logic [1:0] REQ_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REQ_FROM   = 3'd1,
        CAP_FROM   = 3'd2,
        REQ_TO     = 3'd3,
        CAP_TO     = 3'd4,
        EMIT       = 3'd5,
        FINISH     = 3'd6,
        CLEAR_DONE = 3'd7
    } state_t;

    state_t                  state_q, state_d;
    logic [INDEX_BITS-1:0]   counter_q, counter_d;
    logic [ADDRESS_BITS-1:0] from_q, from_d;
    logic [ADDRESS_BITS-1:0] to_q, to_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            from_q    <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            from_q    <= from_d;
            to_q      <= to_d;
        end
    end

    // Read data arrives one cycle after a request, so each CAP state samples it.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        from_d    = from_q;
        to_d      = to_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    counter_d = '0;
                    state_d   = REQ_FROM;
                end
            end
            REQ_FROM: begin
                if (!stall) state_d = CAP_FROM;
            end
            CAP_FROM: begin
                from_d  = bus.lbr_data[ADDRESS_BITS-1:0];
                state_d = REQ_TO;
            end
            REQ_TO: begin
                if (!stall) state_d = CAP_TO;
            end
            CAP_TO: begin
                to_d    = bus.lbr_data[ADDRESS_BITS-1:0];
                state_d = EMIT;
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (counter_q == LAST_INDEX) begin
                        state_d = FINISH;
                    end else begin
                        counter_d = counter_q + INDEX_BITS'(1);
                        state_d   = REQ_FROM;
                    end
                end
            end
            FINISH: begin
`ifdef LBR_CLEAR_ON_DRAIN_EN
                if (!stall) state_d = CLEAR_DONE;
`else
                state_d = IDLE;
`endif
            end
            CLEAR_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Word 2k is the source PC of entry k and word 2k+1 its target PC.
    always_comb begin
        bus.lbr_req   = REQ_NONE;
        bus.lbr_addr  = '0;
        bus.out_valid = 1'b0;
        bus.out_index = '0;
        bus.out_from  = from_q;
        bus.out_to    = to_q;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            REQ_FROM: begin
                busy = 1'b1;
                if (!stall) begin
                    bus.lbr_req  = REQ_READ;
                    bus.lbr_addr = DATA_WIDTH'({counter_q, 1'b0});
                end
            end
            REQ_TO: begin
                busy = 1'b1;
                if (!stall) begin
                    bus.lbr_req  = REQ_READ;
                    bus.lbr_addr = DATA_WIDTH'({counter_q, 1'b1});
                end
            end
            CAP_FROM, CAP_TO: begin
                busy = 1'b1;
            end
            EMIT: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_index = counter_q;
            end
            FINISH: begin
`ifdef LBR_CLEAR_ON_DRAIN_EN
                busy = 1'b1;
                if (!stall) bus.lbr_req = REQ_CLEAR;
`else
                done = 1'b1;
`endif
            end
            CLEAR_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: doc/lbr_drain_reader.md
Name: lbr_drain_reader

Overview:
- Read-side engine for the Last Branch Record unit. On a start pulse it walks every LBR entry by issuing read requests on the LBR request/address interface and captures each returned word.
- It pairs each source PC with its target PC and presents the records, one at a time, on a valid/ready stream to a downstream CFI monitor or trace sink.
- It sits between the LBR unit and the monitor, replacing ad-hoc software reads.

Parameters:
- DATA_WIDTH, 16, width of the LBR read data and the read address bus.
- ADDRESS_BITS, 12, width of the PC fields in each record.
- LBR_DEPTH, 8, number of branch records held by the LBR; must be a power of two and at least 2.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a drain; ignored while busy.
- stall  input  1  pipeline stall; while high, no new LBR request is issued.
- lbr_req  output  2  2'b00 = idle, 2'b10 = read, 2'b11 = clear.
- lbr_addr  output  DATA_WIDTH  LBR word address for a read.
- lbr_data  input  DATA_WIDTH  LBR read data, valid exactly one cycle after a read request.
- out_valid  output  1  a record is presented on the stream.
- out_ready  input  1  sink accepts the record.
- out_from  output  ADDRESS_BITS  branch source PC, taken from lbr_data[ADDRESS_BITS-1:0].
- out_to  output  ADDRESS_BITS  branch target PC.
- out_index  output  log2(LBR_DEPTH)  entry number of the current record.
- busy  output  1  high from the cycle after start until the done pulse.
- done  output  1  one-cycle pulse when the drain completes.

Behaviour:
- LBR word map: word 2k holds the source PC of entry k, word 2k+1 holds the target PC of entry k, for k = 0..LBR_DEPTH-1.
- Reset: state = IDLE; all outputs 0; lbr_req = 2'b00; entry counter = 0. Reset mid-drain aborts immediately with no clear request and no done pulse.
- State IDLE:
  - start=1 sets busy=1, counter=0, and moves to REQ_FROM.
- State REQ_FROM:
  - If stall=0: drive lbr_req=2'b10 and lbr_addr={counter,0}, then go to CAP_FROM.
  - If stall=1: lbr_req=2'b00 and the state holds.
- State CAP_FROM: register lbr_data[ADDRESS_BITS-1:0] into out_from, then go to REQ_TO. Capture ignores stall.
- State REQ_TO: same as REQ_FROM but with lbr_addr={counter,1}, then go to CAP_TO.
- State CAP_TO: capture into out_to, then go to EMIT.
- State EMIT:
  - out_valid=1 and out_index=counter.
  - Record fields stay stable until out_ready=1.
  - On the handshake: if counter == LBR_DEPTH-1, go to FINISH; otherwise increment counter and go to REQ_FROM.
- State FINISH: optional clear (see below), then done=1 for one cycle, busy=0, return to IDLE.
- lbr_req is 2'b00 in every cycle not listed above; lbr_addr is 0 when lbr_req=2'b00.
- Throughput: minimum 5 cycles per record (req, cap, req, cap, emit) with out_ready tied high and stall=0.
- Only the low ADDRESS_BITS of lbr_data are used; the upper bits are discarded.
- The counter does not wrap mid-drain. A start during busy or in the done cycle is dropped.
- out_valid never asserts outside EMIT.

Optional Feature:
- Macro: LBR_CLEAR_ON_DRAIN_EN.
- When defined: FINISH first waits for stall=0, then drives lbr_req=2'b11 with lbr_addr=0 for exactly one cycle. done pulses in the following cycle.
- When undefined: FINISH asserts done in its first cycle, and lbr_req=2'b11 is never driven.

Test Plan:
- LBR model with word 2k=k and word 2k+1=1<<k; start pulse with out_ready=1 -> 8 records, (from,to) = (0,1),(1,2),(2,4),...,(7,0x080), out_index 0..7, one done pulse, busy low afterwards. The last record is 0x080 because a 12-bit target holds 1<<7.
- out_ready held low for 10 cycles at record 3 -> out_valid stays high, out_from=3 and out_to=8 stay stable, no lbr_req issued, and the drain resumes after ready.
- stall high for 4 cycles while in REQ_TO of entry 2 -> lbr_req=00 during the stall, then lbr_addr=5 is issued; the record is still (2,4).
- start pulsed again at record 4 -> ignored; exactly 8 records and 1 done.
- reset asserted while in CAP_FROM of entry 5 -> next cycle all outputs are 0, no clear, no done; a new start drains from entry 0.
- LBR_CLEAR_ON_DRAIN_EN defined -> exactly one lbr_req=2'b11 cycle after record 7 is accepted, then done. With the macro undefined, no 2'b11 ever appears.
